// File: rtl/netlist_eval_engine.sv
// Sequential evaluator for 2-input-cell netlists: executes gate records in topological
// order against an internal net file and streams probed net values out.
module netlist_eval_engine #(
    parameter int NET_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [3:0]       rec_op,
    input  logic [NET_W-1:0] rec_a,
    input  logic [NET_W-1:0] rec_b,
    input  logic [NET_W-1:0] rec_y,
    input  logic             rec_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NET_W-1:0] out_net,
    output logic             out_val,
    output logic             done,
    output logic             err
);

    localparam int NETS = 1 << NET_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NETS-1:0]  value_q, value_d;
    logic [NETS-1:0]  written_q, written_d;
    logic             wr_valid_q, wr_valid_d;
    logic [NET_W-1:0] wr_addr_q, wr_addr_d;
    logic             wr_val_q, wr_val_d;
    logic             last_pend_q, last_pend_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [NET_W-1:0] out_net_q, out_net_d;
    logic             out_val_q, out_val_d;

    logic out_stall;
    logic accept;
    logic fwd_a, fwd_b, fwd_y;
    logic a_wr, b_wr, y_wr;
    logic a_val, b_val;
    logic is_logic, uses_b, is_setpi, is_probe, is_illegal;
    logic result;
    logic rd_err, dd_err;

    assign out_stall = out_valid_q && !out_ready;
    assign accept    = rec_valid && rec_ready;

    // The pending write register is newer than the net file, so it wins on a match.
    assign fwd_a = wr_valid_q && (wr_addr_q == rec_a);
    assign fwd_b = wr_valid_q && (wr_addr_q == rec_b);
    assign fwd_y = wr_valid_q && (wr_addr_q == rec_y);
    assign a_wr  = written_q[rec_a] || fwd_a;
    assign b_wr  = written_q[rec_b] || fwd_b;
    assign y_wr  = written_q[rec_y] || fwd_y;
    assign a_val = a_wr && (fwd_a ? wr_val_q : value_q[rec_a]);
    assign b_val = b_wr && (fwd_b ? wr_val_q : value_q[rec_b]);

    assign is_logic   = (rec_op <= 4'd7);
    assign uses_b     = (rec_op <= 4'd5);
    assign is_setpi   = (rec_op == 4'd8);
    assign is_probe   = (rec_op == 4'd9);
    assign is_illegal = (rec_op >= 4'd10);

    always_comb begin
        result = 1'b0;
        case (rec_op)
            4'd0:    result = a_val & b_val;
            4'd1:    result = ~(a_val & b_val);
            4'd2:    result = a_val | b_val;
            4'd3:    result = ~(a_val | b_val);
            4'd4:    result = a_val ^ b_val;
            4'd5:    result = ~(a_val ^ b_val);
            4'd6:    result = ~a_val;
            4'd7:    result = a_val;
            4'd8:    result = rec_a[0];
            default: result = 1'b0;
        endcase
    end

    assign rd_err = (is_logic && (!a_wr || (uses_b && !b_wr))) || (is_probe && !a_wr);
    assign dd_err = (is_logic || is_setpi) && y_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_pend_q && !out_stall) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rec_ready = (state_q != S_DONE) && !out_stall;
        done      = (state_q == S_DONE);
    end

    always_comb begin
        value_d     = value_q;
        written_d   = written_q;
        wr_valid_d  = accept && (is_logic || is_setpi);
        wr_addr_d   = rec_y;
        wr_val_d    = result;
        last_pend_d = last_pend_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_net_d   = out_net_q;
        out_val_d   = out_val_q;

        if (wr_valid_q) begin
            value_d[wr_addr_q]   = wr_val_q;
            written_d[wr_addr_q] = 1'b1;
        end
        if (accept && rec_last) begin
            last_pend_d = 1'b1;
        end
        if (accept && (rd_err || dd_err || is_illegal)) begin
            err_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && is_probe) begin
            out_valid_d = 1'b1;
            out_net_d   = rec_a;
            out_val_d   = a_val;
        end
        // Frame teardown: values survive, but nothing counts as driven any more.
        if (state_q == S_DONE) begin
            written_d   = '0;
            err_d       = 1'b0;
            last_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= '0;
            written_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_val_q    <= 1'b0;
            last_pend_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_net_q   <= '0;
            out_val_q   <= 1'b0;
        end else begin
            value_q     <= value_d;
            written_q   <= written_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_val_q    <= wr_val_d;
            last_pend_q <= last_pend_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_net_q   <= out_net_d;
            out_val_q   <= out_val_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_net   = out_net_q;
    assign out_val   = out_val_q;
    assign err       = err_q;

endmodule

// File: doc/netlist_eval_engine.md
# netlist_eval_engine

Sequential evaluator for mapped gate-level netlists built from the team's 2-input cell library (and/nand/or/nor/xor/xnor/not/buf). It consumes a stream of gate records in topological order, holds every net value in an internal net file, and returns probed net values on a result stream. It is the consumer of the netlists our mapping flow emits, and is used on-chip to check a mapped netlist against its expected outputs.

## Interface
- NET_W, 7: net index width; the net file holds 2**NET_W nets.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rec_valid  in  1  gate record present
- rec_ready  out  1  engine accepts record this cycle
- rec_op  in  4  opcode: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a), 8 SETPI (net y <= rec_a[0]), 9 PROBE(a); 10–15 illegal
- rec_a, rec_b, rec_y  in  NET_W  operand and destination net indices (rec_b ignored by ops 6–9; rec_y ignored by op 9)
- rec_last  in  1  final record of the frame
- out_valid  out  1  probe result valid
- out_ready  in  1  downstream accepts the probe result
- out_net  out  NET_W  probed net index
- out_val  out  1  probed net value
- done  out  1  one-cycle pulse: frame complete
- err  out  1  frame error flag, valid in the done cycle

## Operation
- Net file: value bit and written bit per net. Reset clears all value and written bits.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on the first accepted record.
  - RUN → DONE in the cycle after the record flagged rec_last retires.
  - DONE lasts one cycle, then → IDLE. done = 1 only in DONE.
  - On DONE → IDLE, all written bits and err are cleared. Net values are kept but have no meaning until rewritten.
- Accept rule: a record transfers on rec_valid & rec_ready.
- rec_ready = 0 in DONE, and 0 while out_valid & !out_ready. Otherwise rec_ready = 1.
- Logic ops (0–7): read a/b from the net file, with forwarding (see Timing). Compute the result and write it to net y; set written[y].
- SETPI: write rec_a[0] to net y; set written[y]. SETPI reads no operands.
- PROBE: load out_net = a and out_val = value(a). out_valid is asserted until out_ready.
- Error conditions. Each sets err; err stays set until the DONE → IDLE transition.
  - A logic op or PROBE reads an operand whose written bit is 0. The value used is 0.
  - A write targets a net whose written bit is already 1 (multiple drivers). The new value still overwrites.
  - An illegal opcode. No write, no probe.
- A record arriving in IDLE with rec_last = 1 is a one-record frame: IDLE → RUN → DONE.

## Timing
- Reset values: rec_ready 1, out_valid 0, out_net 0, out_val 0, done 0, err 0; state IDLE.
- Write latency: a record accepted at edge k updates the net file at edge k+1.
- Forwarding: a record accepted at edge k+1 that reads the net written by the record accepted at edge k sees the new value and the new written bit. Back-to-back dependent records run at full rate, one record per cycle.
- PROBE latency: a PROBE accepted at edge k gives out_valid = 1 after edge k (the next cycle). out_net/out_val stay stable until out_valid & out_ready.
- Back-to-back probes with out_ready held high: one result per cycle.
- Backpressure: while out_valid & !out_ready, rec_ready = 0 and no record is accepted.
- DONE timing: done is asserted one cycle after the last record is accepted, or once its probe result has transferred if that is later. err is valid in the same cycle as done.
- Asynchronous reset mid-frame: all state and flags clear immediately. The partial frame is discarded and no done pulse is generated.

## Test plan
- SETPI n3=1, SETPI n4=0, AND y5=3,4, PROBE 5 (last) → out_net 5, out_val 0; done one cycle later; err 0.
- Forwarding: SETPI n1=1, NOT y2=1, XNOR y7=2,1, PROBE 7, all back-to-back → out_val 0, no stall cycles.
- Backpressure: PROBE n3=1 with out_ready low for 4 cycles → rec_ready 0 for 4 cycles; out_val held at 1; next record accepted in the cycle out_ready rises.
- Errors: NOR y9 reading unwritten n20 → err 1 at done. Double-drive of n5 → err 1. Opcode 12 → err 1, no write. err reads 0 in the following frame.
- Reset: assert rst_n low mid-frame after 3 records → out_valid 0, done 0, err 0, rec_ready 1 after release; PROBE of n3 in the new frame flags err.
- Single-record frame: PROBE of an unwritten net with rec_last → out_val 0; done asserted; err 1.
